// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, byte type and word sizing.
package uart_tx_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_HI,
      WAIT_LO,
      NEXT
   } tx_arb_state_t;

   typedef logic [7:0] byte_t;

   function automatic int nbytes(input int dataW);
      return dataW / 8;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The master modport is the arbiter; slave is the surrounding logic.
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 16
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ack;
   logic                    tx_busy;
   logic                    tx_start;
   byte_t                   tx_data;
   logic [GW-1:0]           grant_id;
   logic                    active;

   modport master (
      input  req, req_data, tx_busy,
      output req_ack, tx_start, tx_data, grant_id, active
   );

   modport slave (
      output req, req_data, tx_busy,
      input  req_ack, tx_start, tx_data, grant_id, active
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] grant_o,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   logic [W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(ptr_i) + k) % N);
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter between N_REQ word sources; grants
// round-robin, latches the word and sends it byte by byte.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 16,
   parameter bit MSB_FIRST = 1'b1,
   parameter int BUSY_TO   = 7
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   uart_tx_arbiter_if.master  bus
);

   localparam int NB = nbytes(DATA_W);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(BUSY_TO + 1);

   tx_arb_state_t     state_q;
   logic [DATA_W-1:0] shift_q;
   logic [CW-1:0]     byteCnt_q;
   logic [TW-1:0]     toCnt_q;
   logic [GW-1:0]     rrPtr_q;
   logic [GW-1:0]     grantId_q;
   logic [N_REQ-1:0]  reqAck_q;
   logic              txStart_q;
   byte_t             txData_q;
   logic              active_q;

   logic [N_REQ-1:0]  winOneHot;
   logic [GW-1:0]     winIdx;
   logic              winAny;
   logic [DATA_W-1:0] winWord;
   byte_t             nextByte;

   rr_arbiter #(.N(N_REQ), .W(GW)) u_rr (
      .req_i   (bus.req),
      .ptr_i   (rrPtr_q),
      .grant_o (winOneHot),
      .idx_o   (winIdx),
      .any_o   (winAny)
   );

   always_comb begin
      winWord = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winOneHot[i]) winWord = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   // The outgoing byte always sits at one end of the shift register.
   assign nextByte = MSB_FIRST ? shift_q[DATA_W-1 -: 8] : shift_q[7:0];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         byteCnt_q <= '0;
         toCnt_q   <= '0;
         rrPtr_q   <= GW'(N_REQ - 1);
         grantId_q <= '0;
         reqAck_q  <= '0;
         txStart_q <= 1'b0;
         txData_q  <= '0;
         active_q  <= 1'b0;
      end else begin
         reqAck_q  <= '0;
         txStart_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (winAny) begin
                  shift_q   <= winWord;
                  grantId_q <= winIdx;
                  rrPtr_q   <= winIdx;
                  reqAck_q  <= winOneHot;
                  active_q  <= 1'b1;
                  byteCnt_q <= '0;
                  state_q   <= LOAD;
               end
            end
            LOAD: begin
               if (!bus.tx_busy) begin
                  txData_q  <= nextByte;
                  txStart_q <= 1'b1;
                  state_q   <= START;
               end
            end
            START: begin
               toCnt_q <= '0;
               state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               if (bus.tx_busy) begin
                  state_q <= WAIT_LO;
               end else if (toCnt_q == TW'(BUSY_TO - 1)) begin
                  state_q <= NEXT;
               end else begin
                  toCnt_q <= toCnt_q + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!bus.tx_busy) state_q <= NEXT;
            end
            NEXT: begin
               if (byteCnt_q == CW'(NB - 1)) begin
                  active_q <= 1'b0;
                  state_q  <= IDLE;
               end else begin
                  byteCnt_q <= byteCnt_q + 1'b1;
                  shift_q   <= MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                  state_q   <= LOAD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ack  = reqAck_q;
   assign bus.tx_start = txStart_q;
   assign bus.tx_data  = txData_q;
   assign bus.grant_id = grantId_q;
   assign bus.active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a round-robin word model
// predicts grants and byte order, a monitor checks them as the DUT emits them.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 16;
   localparam bit MSB_FIRST = 1'b1;
   localparam int BUSY_TO   = 7;
   localparam int NB        = DATA_W / 8;

   logic clk = 1'b0;
   logic rstN;
   logic busyDrv;
   logic busyForce;

   int nChecks = 0;
   int nFails  = 0;
   int cycleCnt = 0;

   byte_t             expBytes[$];
   int                expGrants[$];
   logic [DATA_W-1:0] words[N_REQ];
   int                modelPtr;
   int                holdTarget;
   int                ackCount;
   int                busyMode;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus();

   assign bus.tx_busy = busyDrv | busyForce;

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST), .BUSY_TO(BUSY_TO)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (bus.master)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic int pickNext(input logic [N_REQ-1:0] s, input int ptr);
      for (int k = 1; k <= N_REQ; k++) begin
         if (s[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
      end
      return -1;
   endfunction

   // Model: rotate through the pending set, each winner becomes lowest priority.
   task automatic applyStimulus(input logic [N_REQ-1:0] set, input int hold);
      logic [N_REQ-1:0] s;
      int nGrants;
      int c;
      s = set;
      nGrants = (hold > 0) ? hold : $countones(set);
      for (int g = 0; g < nGrants; g++) begin
         c = pickNext(s, modelPtr);
         modelPtr = c;
         expGrants.push_back(c);
         for (int b = 0; b < NB; b++) begin
            if (MSB_FIRST) expBytes.push_back(words[c][(NB-1-b)*8 +: 8]);
            else           expBytes.push_back(words[c][b*8 +: 8]);
         end
         if (hold == 0) s[c] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = words[i];
      ackCount   = 0;
      holdTarget = hold;
      bus.req    = set;
   endtask

   task automatic flushModel();
      expGrants.delete();
      expBytes.delete();
   endtask

   task automatic waitDone(input string name);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #2;
         if (expGrants.size() == 0 && expBytes.size() == 0 && bus.active === 1'b0 && bus.req === '0) break;
      end
      checkOutput({name, " outstanding"}, 64'(expGrants.size() + expBytes.size()), 0);
      checkOutput({name, " idle"}, bus.active, 0);
      flushModel();
      bus.req = '0;
      repeat (2) @(posedge clk);
   endtask

   task automatic waitStart(output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clk); #1;
         if (bus.tx_start === 1'b1) begin
            t  = cycleCnt;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      bus.req = '0;
      flushModel();
      modelPtr = N_REQ - 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial forever begin
      @(posedge clk);
      cycleCnt++;
   end

   // Scoreboard monitor: every ack and every byte strobe consumes one prediction.
   int    monGrant;
   byte_t monByte;
   initial forever begin
      @(posedge clk); #1;
      if (rstN === 1'b1) begin
         if (bus.req_ack !== '0) begin
            if (expGrants.size() == 0) begin
               checkOutput("unexpected req_ack", bus.req_ack, 0);
            end else begin
               monGrant = expGrants.pop_front();
               checkOutput("req_ack", bus.req_ack, 64'(1) << monGrant);
               checkOutput("grant_id", bus.grant_id, monGrant);
               checkOutput("active at ack", bus.active, 1);
            end
         end
         if (bus.tx_start === 1'b1) begin
            if (expBytes.size() == 0) begin
               checkOutput("unexpected tx_start", bus.tx_start, 0);
            end else begin
               monByte = expBytes.pop_front();
               checkOutput("tx_data", bus.tx_data, monByte);
            end
         end
      end
   end

   // Requesters drop their level in the ack cycle unless told to keep it held.
   initial forever begin
      @(posedge clk); #1;
      if (rstN === 1'b1 && bus.req_ack !== '0) begin
         ackCount++;
         if (holdTarget == 0) bus.req = bus.req & ~bus.req_ack;
         else if (ackCount >= holdTarget) bus.req = '0;
      end
   end

   // Transmitter model: optional short delay, then busy for a random few cycles.
   int dCnt = 0;
   int bCnt = 0;
   initial begin
      busyDrv = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rstN !== 1'b1) begin
            busyDrv = 1'b0;
            dCnt = 0;
            bCnt = 0;
         end else if (dCnt > 0) begin
            dCnt--;
            if (dCnt == 0) busyDrv = 1'b1;
         end else if (bCnt > 0) begin
            bCnt--;
            if (bCnt == 0) busyDrv = 1'b0;
         end else if (bus.tx_start === 1'b1 && busyMode == 0) begin
            dCnt = $urandom_range(0, 2);
            bCnt = $urandom_range(1, 4);
            if (dCnt == 0) busyDrv = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   int  t0, t1, cnt;
   bit  ok0, ok1;
   initial begin
      rstN       = 1'b0;
      busyForce  = 1'b0;
      busyMode   = 0;
      holdTarget = 0;
      ackCount   = 0;
      modelPtr   = N_REQ - 1;
      bus.req    = '0;
      bus.req_data = '0;
      for (int i = 0; i < N_REQ; i++) words[i] = '0;
      #12;
      checkOutput("reset tx_start", bus.tx_start, 0);
      checkOutput("reset tx_data", bus.tx_data, 0);
      checkOutput("reset req_ack", bus.req_ack, 0);
      checkOutput("reset active", bus.active, 0);
      checkOutput("reset grant_id", bus.grant_id, 0);
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] single word latency");
      words[0] = 16'hA55A;
      applyStimulus(4'b0001, 0);
      @(posedge clk); #1;
      checkOutput("ack cycle 1", bus.req_ack, 4'b0001);
      checkOutput("active cycle 1", bus.active, 1);
      @(posedge clk); #1;
      checkOutput("tx_start cycle 2", bus.tx_start, 1);
      checkOutput("first byte", bus.tx_data, 8'hA5);
      waitDone("single word");

      $display("[TB] round robin with all requests held");
      doReset();
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      applyStimulus(4'b1111, 5);
      waitDone("round robin");

      $display("[TB] priority after grant");
      words[1] = 16'h0B0B;
      applyStimulus(4'b0010, 0);
      waitDone("prime ptr=1");
      words[0] = 16'hC0DE; words[2] = 16'h2BAD;
      applyStimulus(4'b0101, 0);
      waitDone("priority 2 before 0");

      $display("[TB] transmitter busy at grant");
      @(negedge clk);
      busyForce = 1'b1;
      words[3] = 16'hBEEF;
      applyStimulus(4'b1000, 0);
      cnt = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.tx_start === 1'b1) cnt++;
      end
      checkOutput("no start while busy", 64'(cnt), 0);
      checkOutput("active while held", bus.active, 1);
      @(negedge clk);
      busyForce = 1'b0;
      waitDone("busy held");

      $display("[TB] busy never rises");
      busyMode = 1;
      words[1] = 16'h6C3E;
      applyStimulus(4'b0010, 0);
      waitStart(t0, ok0);
      waitStart(t1, ok1);
      checkOutput("timeout both starts seen", 64'(ok0 & ok1), 1);
      checkOutput("timeout gap in range", 64'((t1 - t0) >= BUSY_TO && (t1 - t0) <= BUSY_TO + 4), 1);
      waitDone("timeout");
      busyMode = 0;

      $display("[TB] randomized phases");
      for (int ph = 0; ph < 20; ph++) begin
         for (int i = 0; i < N_REQ; i++) words[i] = DATA_W'($urandom);
         busyMode = ($urandom_range(0, 4) == 0) ? 1 : 0;
         applyStimulus(N_REQ'($urandom_range(1, 15)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
         waitDone("random phase");
      end
      busyMode = 0;

      $display("[TB] reset during busy-low wait");
      words[2] = 16'h7E81;
      applyStimulus(4'b0100, 0);
      waitStart(t0, ok0);
      checkOutput("pre-reset start seen", 64'(ok0), 1);
      busyForce = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("midreset tx_start", bus.tx_start, 0);
      checkOutput("midreset tx_data", bus.tx_data, 0);
      checkOutput("midreset req_ack", bus.req_ack, 0);
      checkOutput("midreset active", bus.active, 0);
      checkOutput("midreset grant_id", bus.grant_id, 0);
      flushModel();
      modelPtr = N_REQ - 1;
      bus.req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      busyForce = 1'b0;
      rstN = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.tx_start === 1'b1) cnt++;
      end
      checkOutput("no start after abandon", 64'(cnt), 0);
      words[0] = 16'h0F0F; words[3] = 16'h3C3C;
      applyStimulus(4'b1001, 0);
      waitDone("post-reset priority");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
